mmio_port_responder: RTL and testbench

- Memory-mapped I/O responder on the CPU memory handshake. The CPU side uses MAR address, `enable` (WMFC), `rnw` and the shared 8-bit bus; the responder answers with MFC, the same way the RAM does.
- It decodes a 16-byte window and buffers CPU writes into a TX FIFO drained by an external valid/ready sink.
- It buffers external valid/ready input into an RX FIFO that the CPU reads.
- Sits beside the RAM at the top level; its MFC is ORed with the RAM's MFC into the control unit.

---
 rtl/mmio_port_responder.sv | 139 +++++++++++++
 tb/tb_mmio_port_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_responder.sv
// mmio_port_responder: 16-byte MMIO window with CPU-visible TX/RX byte FIFOs answered via MFC
module mmio_port_responder #(
    parameter logic [3:0] BASE  = 4'hF,
    parameter int         DEPTH = 4,
    parameter int         WS    = 1
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] MAR,
    input  logic       enable,
    input  logic       rnw,
    inout  wire  [7:0] bus,
    output logic       MFC,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);
    localparam int AW = (DEPTH == 4) ? 2 : 1;
    localparam logic [2:0] FULL = 3'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    state_t state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [3:0] off_q, off_d;
    logic rnw_q, rnw_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic ovf_q, ovf_d;
    logic mfc_q, mfc_d;
    logic drv_q, drv_d;
    logic [7:0] tx_mem_q [DEPTH];
    logic [7:0] tx_mem_d [DEPTH];
    logic [7:0] rx_mem_q [DEPTH];
    logic [7:0] rx_mem_d [DEPTH];
    logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [2:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic req, to_ack, tx_full, tx_empty, rx_full, rx_empty;
    logic tx_req, tx_push, tx_pop, rx_push, rx_pop;
    logic [7:0] status;

    assign tx_full  = tx_cnt_q == FULL;
    assign tx_empty = tx_cnt_q == 3'd0;
    assign rx_full  = rx_cnt_q == FULL;
    assign rx_empty = rx_cnt_q == 3'd0;
    assign tx_valid = !tx_empty;
    assign rx_ready = !rx_full;
    assign tx_data  = tx_mem_q[tx_rp_q];
    assign MFC      = mfc_q;
    assign bus      = (drv_q && RST_N) ? rdata_q : 8'bz;
    assign status   = {rx_cnt_q, ovf_q, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req     = enable && (MAR[7:4] == BASE);
        unique case (state_q)
            IDLE: if (req) begin
                state_d = (WS == 0) ? ACK : WAIT;
                cnt_d   = 3'd0;
            end
            WAIT: if (cnt_q == 3'(WS - 1)) state_d = ACK;
                  else cnt_d = cnt_q + 3'd1;
            ACK:  state_d = HOLD;
            HOLD: if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        to_ack   = (state_d == ACK) && (state_q != ACK);
        off_d    = (state_q == IDLE) ? MAR[3:0] : off_q;
        rnw_d    = (state_q == IDLE) ? rnw : rnw_q;
        wdata_d  = (state_q == IDLE) ? bus : wdata_q;
        tx_pop   = tx_valid && tx_ready;
        tx_req   = to_ack && !rnw_d && (off_d == 4'd0);
        tx_push  = tx_req && (!tx_full || tx_pop);
        rx_push  = rx_valid && rx_ready;
        rx_pop   = to_ack && rnw_d && (off_d == 4'd0) && !rx_empty;
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        if (tx_push) tx_mem_d[tx_wp_q] = wdata_d;
        if (rx_push) rx_mem_d[rx_wp_q] = rx_data;
        tx_wp_d  = tx_wp_q + AW'(tx_push);
        tx_rp_d  = tx_rp_q + AW'(tx_pop);
        rx_wp_d  = rx_wp_q + AW'(rx_push);
        rx_rp_d  = rx_rp_q + AW'(rx_pop);
        tx_cnt_d = tx_cnt_q + 3'(tx_push) - 3'(tx_pop);
        rx_cnt_d = rx_cnt_q + 3'(rx_push) - 3'(rx_pop);
        rdata_d  = !(to_ack && rnw_d) ? rdata_q :
                   (off_d == 4'd0) ? (rx_empty ? 8'h00 : rx_mem_q[rx_rp_q]) :
                   (off_d == 4'd1) ? status : 8'h00;
        ovf_d    = (tx_req && tx_full && !tx_pop) ? 1'b1 :
                   (to_ack && rnw_d && (off_d == 4'd1)) ? 1'b0 : ovf_q;
        mfc_d    = state_q == ACK;
        drv_d    = (state_q == ACK) && rnw_q;
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            off_q    <= '0;
            rnw_q    <= 1'b1;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ovf_q    <= 1'b0;
            mfc_q    <= 1'b0;
            drv_q    <= 1'b0;
            tx_mem_q <= '{default: '0};
            rx_mem_q <= '{default: '0};
            tx_wp_q  <= '0;
            tx_rp_q  <= '0;
            rx_wp_q  <= '0;
            rx_rp_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            off_q    <= off_d;
            rnw_q    <= rnw_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ovf_q    <= ovf_d;
            mfc_q    <= mfc_d;
            drv_q    <= drv_d;
            tx_mem_q <= tx_mem_d;
            rx_mem_q <= rx_mem_d;
            tx_wp_q  <= tx_wp_d;
            tx_rp_q  <= tx_rp_d;
            rx_wp_q  <= rx_wp_d;
            rx_rp_q  <= rx_rp_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
        end
    end
endmodule

// File: tb/tb_mmio_port_responder.sv
// tb_mmio_port_responder: scoreboard bench for the MMIO port responder
module tb_mmio_port_responder;
    localparam int WS = 1;

    logic CLK = 1'b0;
    logic RST_N = 1'b0;
    logic enable = 1'b0;
    logic rnw = 1'b1;
    logic tx_ready = 1'b0;
    logic rx_valid = 1'b0;
    logic bus_oe = 1'b0;
    logic [7:0] MAR = 8'h00;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] bus_drv = 8'h00;
    wire  [7:0] bus;
    logic MFC, tx_valid, rx_ready;
    logic [7:0] tx_data;
    int n_tests = 0;
    int n_fail = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rd_q[$];

    assign bus = bus_oe ? bus_drv : 8'bz;
    pullup (bus);

    always #5 CLK = ~CLK;

    mmio_port_responder #(.BASE(4'hF), .DEPTH(4), .WS(WS)) dut (
        .CLK(CLK), .RST_N(RST_N), .MAR(MAR), .enable(enable), .rnw(rnw), .bus(bus),
        .MFC(MFC), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N && tx_valid && tx_ready) begin
            chk("tx_sb_nonempty", 8'(tx_q.size() != 0), 8'd1);
            if (tx_q.size() != 0) chk("tx_data", tx_data, tx_q.pop_front());
        end
    end

    task automatic access(input logic [7:0] addr, input logic r, input logic [7:0] wd, input int hold);
        int n = 0;
        int extra = 0;
        bit seen = 1'b0;
        MAR = addr;
        rnw = r;
        bus_drv = wd;
        bus_oe = !r;
        enable = 1'b1;
        while (!seen && n < 20) begin
            @(negedge CLK);
            n++;
            seen = MFC;
        end
        chk("mfc_seen", 8'(seen), 8'd1);
        chk("mfc_latency", 8'(n), 8'(WS + 3));
        if (r && rd_q.size() != 0) chk("rdata", bus, rd_q.pop_front());
        repeat (hold) begin
            @(negedge CLK);
            extra += int'(MFC);
        end
        chk("mfc_once", 8'(extra), 8'd0);
        @(posedge CLK); #1;
        enable = 1'b0;
        bus_oe = 1'b0;
        @(negedge CLK);
        chk("mfc_low", 8'(MFC), 8'd0);
        @(posedge CLK); #1;
    endtask

    task automatic rd(input logic [7:0] addr, input logic [7:0] exp, input int hold);
        rd_q.push_back(exp);
        access(addr, 1'b1, 8'h00, hold);
    endtask

    task automatic wr(input logic [7:0] addr, input logic [7:0] d, input bit acc);
        if (acc) tx_q.push_back(d);
        access(addr, 1'b0, d, 0);
    endtask

    task automatic drain();
        int k = 0;
        tx_ready = 1'b1;
        while (tx_valid && k < 20) begin
            @(posedge CLK); #1;
            k++;
        end
        tx_ready = 1'b0;
        chk("tx_valid_low", 8'(tx_valid), 8'd0);
        chk("tx_sb_empty", 8'(tx_q.size()), 8'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n;
        bit seen;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_mfc", 8'(MFC), 8'd0);
        chk("rst_tx_valid", 8'(tx_valid), 8'd0);
        chk("rst_rx_ready", 8'(rx_ready), 8'd1);
        chk("rst_bus_z", bus, 8'hFF);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        wr(8'hF0, 8'h5A, 1'b1);
        chk("w1_tx_valid", 8'(tx_valid), 8'd1);
        chk("w1_tx_data", tx_data, 8'h5A);
        drain();

        for (int i = 1; i <= 5; i++) wr(8'hF0, 8'(i), i <= 4);
        chk("ovf_tx_data", tx_data, 8'h01);
        rd(8'hF1, 8'h19, 0);
        rd(8'hF1, 8'h09, 0);
        drain();

        rx_valid = 1'b1;
        rx_data = 8'hA1;
        @(posedge CLK); #1;
        chk("rx_ready_1", 8'(rx_ready), 8'd1);
        rx_data = 8'hB2;
        @(posedge CLK); #1;
        chk("rx_ready_2", 8'(rx_ready), 8'd1);
        rx_valid = 1'b0;
        rd(8'hF1, 8'h42, 0);
        rd(8'hF0, 8'hA1, 0);
        rd(8'hF0, 8'hB2, 0);
        rd(8'hF0, 8'h00, 0);
        chk("rx_ready_end", 8'(rx_ready), 8'd1);

        MAR = 8'h30;
        rnw = 1'b1;
        enable = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge CLK);
            bad += int'(MFC) + int'(bus !== 8'hFF);
        end
        @(posedge CLK); #1;
        enable = 1'b0;
        chk("decode_miss", 8'(bad), 8'd0);
        rd(8'hF7, 8'h00, 0);
        wr(8'hF7, 8'h99, 1'b0);
        chk("decode_w_tx", 8'(tx_valid), 8'd0);
        rd(8'hF1, 8'h0A, 0);

        rd(8'hF2, 8'h00, 6);
        MAR = 8'hF0;
        rnw = 1'b0;
        bus_drv = 8'h33;
        bus_oe = 1'b1;
        enable = 1'b1;
        @(posedge CLK); #1;
        RST_N = 1'b0;
        enable = 1'b0;
        bus_oe = 1'b0;
        bad = 0;
        repeat (3) begin
            @(negedge CLK);
            bad += int'(MFC);
        end
        @(posedge CLK); #1;
        RST_N = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            bad += int'(MFC) + int'(bus !== 8'hFF);
        end
        chk("rst_abort", 8'(bad), 8'd0);
        chk("rst_abort_tx", 8'(tx_valid), 8'd0);
        chk("rst_abort_rx", 8'(rx_ready), 8'd1);
        @(posedge CLK); #1;
        rd(8'hF1, 8'h0A, 0);

        for (int i = 0; i < 4; i++) wr(8'hF0, 8'h10 + 8'(i), 1'b1);
        tx_q.push_back(8'h77);
        MAR = 8'hF0;
        rnw = 1'b0;
        bus_drv = 8'h77;
        bus_oe = 1'b1;
        enable = 1'b1;
        @(posedge CLK); #1;
        tx_ready = 1'b1;
        @(posedge CLK); #1;
        tx_ready = 1'b0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            @(negedge CLK);
            n++;
            seen = MFC;
        end
        chk("conc_mfc", 8'(seen), 8'd1);
        @(posedge CLK); #1;
        enable = 1'b0;
        bus_oe = 1'b0;
        @(posedge CLK); #1;
        rd(8'hF1, 8'h09, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
